router_switch: RTL and testbench
================================

ROUTER_SWITCH -- requirements
Module: router_switch

Interface
REQ-001 SHALL have parameter CHANNELS, default 5: number of input and output ports.
REQ-002 SHALL have parameter FLIT_WIDTH, default 8: flit data width.
REQ-003 SHALL have parameter ADDR_BITS, default 3: flit buffer address width.
REQ-004 SHALL have parameter DEST_BITS, default 3: destination field width; must be at least clog2(CHANNELS).
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port rx_req, input, CHANNELS: per-input switch request.
REQ-008 SHALL have port rx_dest, input, CHANNELS*DEST_BITS: per-input requested output; stable while rx_req is high.
REQ-009 SHALL have port rx_ack, output, CHANNELS: per-input grant.
REQ-010 SHALL have port rx_buf_addr, output, CHANNELS*ADDR_BITS: buffer read address to each input.
REQ-011 SHALL have port rx_buf_data, input, CHANNELS*FLIT_WIDTH: buffer read data from each input.
REQ-012 SHALL have port tx_req, output, CHANNELS: per-output packet-available request to tx.
REQ-013 SHALL have port tx_done, input, CHANNELS: one-cycle pulse from tx when the last flit has been sent.
REQ-014 SHALL have port tx_buf_addr, input, CHANNELS*ADDR_BITS: read address from each tx.
REQ-015 SHALL have port tx_buf_data, output, CHANNELS*FLIT_WIDTH: flit data to each tx.

Function
REQ-016 SHALL keep one FSM per output o with states IDLE, BUSY and RELEASE, plus a round-robin pointer ptr[o] and a selected-input register sel[o].
REQ-017 In IDLE, the output SHALL form candidates from inputs i with rx_req[i]=1 and rx_dest[i]=o, excluding inputs owned by any output.
REQ-018 In IDLE, the output SHALL select the first candidate at or after ptr[o], modulo CHANNELS.
REQ-019 On a selection, the FSM SHALL go to BUSY and set sel[o], with rx_ack[sel] and tx_req[o] high from the following cycle (1-cycle grant latency).
REQ-020 On a selection, ptr[o] SHALL be set to (sel+1) mod CHANNELS, wrapping CHANNELS-1 to 0.
REQ-021 In BUSY: rx_buf_addr[sel]=tx_buf_addr[o] and tx_buf_data[o]=rx_buf_data[sel], both combinational with zero latency.
REQ-022 In BUSY, tx_done[o]=1 SHALL move the FSM to RELEASE; tx_req[o] falls the next cycle and rx_ack stays high.
REQ-023 In RELEASE, when rx_req[sel]=0 the FSM SHALL drop rx_ack[sel] next cycle and return to IDLE (4-phase handshake).
REQ-024 In RELEASE, requests from other inputs SHALL wait and be arbitrated from IDLE only.
REQ-025 rx_buf_addr[i] SHALL be 0 when input i is not selected by any BUSY output; tx_buf_data[o] SHALL be 0 when output o is not BUSY.
REQ-026 A request with rx_dest >= CHANNELS SHALL never be granted; rx_ack stays 0.
REQ-027 tx_done outside BUSY SHALL be ignored.
REQ-028 An rx_req drop during BUSY SHALL be ignored until RELEASE; this is a protocol violation and the packet still completes.
REQ-029 An input SHALL be owned by at most one output; rx_ack SHALL be one-hot-or-zero per input.

Reset
REQ-030 While reset=0, all FSMs SHALL be in IDLE, ptr=0, sel=0, and rx_ack, tx_req, rx_buf_addr, tx_buf_data and the counters SHALL be 0, asynchronously, including mid-packet.
REQ-031 After reset deasserts, the first arbitration SHALL occur at the first rising clk edge.

Configuration
REQ-032 With macro ROUTER_SWITCH_STATS_EN defined, the block SHALL add output grant_count (CHANNELS*16): per-output 16-bit grants, saturating at 0xFFFF.
REQ-033 With ROUTER_SWITCH_STATS_EN defined, the block SHALL add output bad_dest_count (16): cycles in which any rx_req=1 with rx_dest >= CHANNELS, saturating.
REQ-034 Without ROUTER_SWITCH_STATS_EN, these ports and counters SHALL be absent and function SHALL be otherwise identical.

Structure
REQ-035 The FSM state encoding (IDLE=0, BUSY=1, RELEASE=2) and the counter width constant SHALL be in the shared package router_pkg.
REQ-036 The per-output FSM, pointer and selection logic SHALL be a sub-module rr_output_alloc, instantiated CHANNELS times; crossbar muxing and ownership masking stay in router_switch.

Verification
REQ-037 Reset mid-BUSY (output 2 serving input 0) -> rx_ack, tx_req and addresses are 0 immediately, and after release output 2 grants the lowest requesting index.
REQ-038 Inputs 1 and 3 request output 2 at the same cycle with ptr=0 -> input 1 is granted first; after its RELEASE, input 3 is granted; ptr[2]=4.
REQ-039 Grant to input 4 from output 0 -> ptr[0] wraps to 0; the next simultaneous requests from 0 and 4 grant input 0.
REQ-040 Input 2 granted by output 1, tx_buf_addr[1]=5, rx_buf_data[2]=0xA5 -> rx_buf_addr[2]=5 and tx_buf_data[1]=0xA5 in the same cycle.
REQ-041 Input 0 with rx_dest=6 for 20 cycles -> no ack, and with the stats macro bad_dest_count=20.
REQ-042 Five inputs to five distinct outputs in the same cycle -> all five granted the next cycle and all five transfers run concurrently.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared definitions for router_switch and rr_output_alloc.
//   state_t   - per-output allocator state (IDLE=0, BUSY=1, RELEASE=2)
//   CNT_WIDTH - width of the optional statistics counters
//   CNT_MAX   - saturation value of those counters
package router_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int                   CNT_WIDTH = 16;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

endpackage

// File: rtl/rr_output_alloc.sv
// rr_output_alloc: per-output round-robin allocator FSM.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   i_cand      - inputs eligible for this output (request, destination match, not owned)
//   i_rx_req    - raw input requests, used to detect the release of the owning input
//   i_tx_done   - end-of-packet pulse from this output's transmitter
//   o_state     - registered FSM state
//   o_sel       - registered index of the input currently owned
module rr_output_alloc
    import router_pkg::*;
#(
    parameter int CHANNELS = 5,
    parameter int SEL_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] i_cand,
    input  logic [CHANNELS-1:0] i_rx_req,
    input  logic                i_tx_done,
    output state_t              o_state,
    output logic [SEL_BITS-1:0] o_sel
);

    state_t              r_state;
    logic [SEL_BITS-1:0] r_sel;
    logic [SEL_BITS-1:0] r_ptr;

    logic                w_found;
    logic [SEL_BITS-1:0] w_pick;
    logic [SEL_BITS-1:0] w_idx;

    // Scan candidates starting at the round-robin pointer, wrapping modulo CHANNELS.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_idx = SEL_BITS'((32'(r_ptr) + k) % CHANNELS);
            if (!w_found && i_cand[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= BUSY;
                        r_sel   <= w_pick;
                        r_ptr   <= (32'(w_pick) == CHANNELS - 1) ? '0 : w_pick + 1'b1;
                    end
                end
                BUSY: begin
                    if (i_tx_done) r_state <= RELEASE;
                end
                RELEASE: begin
                    // Hold the grant until the owning input drops its request.
                    if (!i_rx_req[r_sel]) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_sel   = r_sel;

endmodule

// File: rtl/router_switch.sv
// router_switch: CHANNELS x CHANNELS packet switch with per-output round-robin
// allocation and a combinational buffer-address / flit-data crossbar.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   rx_req/rx_dest/rx_ack      - per-input request, destination and grant
//   rx_buf_addr/rx_buf_data    - read port into each input's flit buffer
//   tx_req/tx_done             - per-output packet-available and end-of-packet
//   tx_buf_addr/tx_buf_data    - read port presented to each transmitter
// Optional (macro ROUTER_SWITCH_STATS_EN):
//   grant_count                - per-output saturating grant counters
//   bad_dest_count             - saturating count of cycles with an invalid destination request
module router_switch
    import router_pkg::*;
#(
    parameter int CHANNELS   = 5,
    parameter int FLIT_WIDTH = 8,
    parameter int ADDR_BITS  = 3,
    parameter int DEST_BITS  = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNELS-1:0]              rx_req,
    input  logic [CHANNELS*DEST_BITS-1:0]    rx_dest,
    output logic [CHANNELS-1:0]              rx_ack,
    output logic [CHANNELS*ADDR_BITS-1:0]    rx_buf_addr,
    input  logic [CHANNELS*FLIT_WIDTH-1:0]   rx_buf_data,
    output logic [CHANNELS-1:0]              tx_req,
    input  logic [CHANNELS-1:0]              tx_done,
    input  logic [CHANNELS*ADDR_BITS-1:0]    tx_buf_addr,
    output logic [CHANNELS*FLIT_WIDTH-1:0]   tx_buf_data
`ifdef ROUTER_SWITCH_STATS_EN
    ,
    output logic [CHANNELS*CNT_WIDTH-1:0]    grant_count,
    output logic [CNT_WIDTH-1:0]             bad_dest_count
`endif
);

    localparam int SEL_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [DEST_BITS-1:0]  w_dest    [CHANNELS];
    logic [ADDR_BITS-1:0]  w_tx_addr [CHANNELS];
    logic [ADDR_BITS-1:0]  w_rx_addr [CHANNELS];
    logic [FLIT_WIDTH-1:0] w_rx_data [CHANNELS];
    logic [FLIT_WIDTH-1:0] w_tx_data [CHANNELS];
    state_t                w_state   [CHANNELS];
    logic [SEL_BITS-1:0]   w_sel     [CHANNELS];
    logic [CHANNELS-1:0]   w_cand    [CHANNELS];
    logic [CHANNELS-1:0]   w_owned;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_port
        assign w_dest[c]    = rx_dest[c*DEST_BITS +: DEST_BITS];
        assign w_tx_addr[c] = tx_buf_addr[c*ADDR_BITS +: ADDR_BITS];
        assign w_rx_data[c] = rx_buf_data[c*FLIT_WIDTH +: FLIT_WIDTH];
        assign rx_buf_addr[c*ADDR_BITS +: ADDR_BITS]    = w_rx_addr[c];
        assign tx_buf_data[c*FLIT_WIDTH +: FLIT_WIDTH]  = w_tx_data[c];
        assign tx_req[c] = (w_state[c] == BUSY);

        rr_output_alloc #(
            .CHANNELS (CHANNELS),
            .SEL_BITS (SEL_BITS)
        ) u_alloc (
            .clk       (clk),
            .reset     (reset),
            .i_cand    (w_cand[c]),
            .i_rx_req  (rx_req),
            .i_tx_done (tx_done[c]),
            .o_state   (w_state[c]),
            .o_sel     (w_sel[c])
        );
    end

    // An input is owned (and acknowledged) while any output is out of IDLE with it selected.
    always_comb begin
        w_owned = '0;
        for (int unsigned o = 0; o < CHANNELS; o++) begin
            if (w_state[o] != IDLE) w_owned[w_sel[o]] = 1'b1;
        end
    end

    assign rx_ack = w_owned;

    // Out-of-range destinations never match an output index, so they are never candidates.
    always_comb begin
        for (int unsigned o = 0; o < CHANNELS; o++) begin
            w_cand[o] = '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                w_cand[o][i] = rx_req[i] && (32'(w_dest[i]) == o) && !w_owned[i];
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            w_rx_addr[c] = '0;
            w_tx_data[c] = '0;
        end
        for (int unsigned o = 0; o < CHANNELS; o++) begin
            if (w_state[o] == BUSY) begin
                w_rx_addr[w_sel[o]] = w_tx_addr[o];
                w_tx_data[o]        = w_rx_data[w_sel[o]];
            end
        end
    end

`ifdef ROUTER_SWITCH_STATS_EN
    logic [CNT_WIDTH-1:0] r_grant_cnt [CHANNELS];
    logic [CNT_WIDTH-1:0] r_bad_cnt;
    logic                 w_bad;

    always_comb begin
        w_bad = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (rx_req[i] && (32'(w_dest[i]) >= CHANNELS)) w_bad = 1'b1;
        end
    end

    // A grant happens on exactly the edges where an IDLE output has any candidate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned o = 0; o < CHANNELS; o++) r_grant_cnt[o] <= '0;
            r_bad_cnt <= '0;
        end else begin
            for (int unsigned o = 0; o < CHANNELS; o++) begin
                if ((w_state[o] == IDLE) && (|w_cand[o]) && (r_grant_cnt[o] != CNT_MAX))
                    r_grant_cnt[o] <= r_grant_cnt[o] + 1'b1;
            end
            if (w_bad && (r_bad_cnt != CNT_MAX)) r_bad_cnt <= r_bad_cnt + 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_stats
        assign grant_count[c*CNT_WIDTH +: CNT_WIDTH] = r_grant_cnt[c];
    end
    assign bad_dest_count = r_bad_cnt;
`endif

endmodule

// File: tb/tb_router_switch.sv
module tb_router_switch;

    localparam int C  = 5;
    localparam int FW = 8;
    localparam int AW = 3;
    localparam int DB = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [C-1:0]      rx_req;
    logic [C*DB-1:0]   rx_dest;
    logic [C-1:0]      rx_ack;
    logic [C*AW-1:0]   rx_buf_addr;
    logic [C*FW-1:0]   rx_buf_data;
    logic [C-1:0]      tx_req;
    logic [C-1:0]      tx_done;
    logic [C*AW-1:0]   tx_buf_addr;
    logic [C*FW-1:0]   tx_buf_data;
`ifdef ROUTER_SWITCH_STATS_EN
    logic [C*16-1:0]   grant_count;
    logic [15:0]       bad_dest_count;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: which input each output is serving, whether its packet
    // has finished, and where its round-robin search starts next.
    int m_own  [C];
    bit m_sent [C];
    int m_ptr  [C];
    int m_gc   [C];
    int m_bad;

    always #5 clk = ~clk;

    router_switch #(
        .CHANNELS   (C),
        .FLIT_WIDTH (FW),
        .ADDR_BITS  (AW),
        .DEST_BITS  (DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_req      (rx_req),
        .rx_dest     (rx_dest),
        .rx_ack      (rx_ack),
        .rx_buf_addr (rx_buf_addr),
        .rx_buf_data (rx_buf_data),
        .tx_req      (tx_req),
        .tx_done     (tx_done),
        .tx_buf_addr (tx_buf_addr),
        .tx_buf_data (tx_buf_data)
`ifdef ROUTER_SWITCH_STATS_EN
        ,
        .grant_count    (grant_count),
        .bad_dest_count (bad_dest_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < C; o++) begin
            m_own[o]  = -1;
            m_sent[o] = 1'b0;
            m_ptr[o]  = 0;
            m_gc[o]   = 0;
        end
        m_bad = 0;
    endtask

    task automatic check_outputs(input string ph);
        logic [C-1:0]    ea;
        logic [C-1:0]    et;
        logic [C*AW-1:0] eaddr;
        logic [C*FW-1:0] edata;
        ea = '0; et = '0; eaddr = '0; edata = '0;
        for (int o = 0; o < C; o++) begin
            if (m_own[o] >= 0) begin
                ea[m_own[o]] = 1'b1;
                if (!m_sent[o]) begin
                    et[o] = 1'b1;
                    eaddr[m_own[o]*AW +: AW] = tx_buf_addr[o*AW +: AW];
                    edata[o*FW +: FW]        = rx_buf_data[m_own[o]*FW +: FW];
                end
            end
        end
        check({ph, "/rx_ack"},      64'(rx_ack),      64'(ea));
        check({ph, "/tx_req"},      64'(tx_req),      64'(et));
        check({ph, "/rx_buf_addr"}, 64'(rx_buf_addr), 64'(eaddr));
        check({ph, "/tx_buf_data"}, 64'(tx_buf_data), 64'(edata));
`ifdef ROUTER_SWITCH_STATS_EN
        for (int o = 0; o < C; o++)
            check({ph, "/grant_count"}, 64'(grant_count[o*16 +: 16]), 64'(m_gc[o]));
        check({ph, "/bad_dest_count"}, 64'(bad_dest_count), 64'(m_bad));
`endif
    endtask

    // Advance the model across one rising edge using the inputs presented now.
    task automatic model_step();
        int nown  [C];
        bit nsent [C];
        bit owned [C];
        bit bad;
        int i;
        for (int k = 0; k < C; k++) owned[k] = 1'b0;
        for (int o = 0; o < C; o++) if (m_own[o] >= 0) owned[m_own[o]] = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < C; k++)
            if (rx_req[k] && int'(rx_dest[k*DB +: DB]) >= C) bad = 1'b1;
        if (bad && m_bad < 65535) m_bad++;
        for (int o = 0; o < C; o++) begin
            nown[o]  = m_own[o];
            nsent[o] = m_sent[o];
            if (m_own[o] < 0) begin
                for (int k = 0; k < C; k++) begin
                    i = (m_ptr[o] + k) % C;
                    if (rx_req[i] && int'(rx_dest[i*DB +: DB]) == o && !owned[i]) begin
                        nown[o]  = i;
                        m_ptr[o] = (i + 1) % C;
                        if (m_gc[o] < 65535) m_gc[o]++;
                        break;
                    end
                end
            end else if (!m_sent[o]) begin
                if (tx_done[o]) nsent[o] = 1'b1;
            end else if (!rx_req[m_own[o]]) begin
                nown[o]  = -1;
                nsent[o] = 1'b0;
            end
        end
        for (int o = 0; o < C; o++) begin
            m_own[o]  = nown[o];
            m_sent[o] = nsent[o];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs("cycle");
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int d);
        rx_req[i] = 1'b1;
        rx_dest[i*DB +: DB] = DB'(d);
    endtask

    task automatic finish_pkt(input int o, input int i);
        tx_done[o] = 1'b1;
        tick();
        tx_done[o] = 1'b0;
        rx_req[i] = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        rx_req = '0; rx_dest = '0; rx_buf_data = '0; tx_done = '0; tx_buf_addr = '0;
        model_reset();
        #2;
        check_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        tick();

        // Invalid destination held for 20 cycles: never granted, counted every cycle.
        set_req(0, 6);
        repeat (20) tick();
        check("bad_dest_ack", 64'(rx_ack), 64'(0));
`ifdef ROUTER_SWITCH_STATS_EN
        check("bad_dest_count20", 64'(bad_dest_count), 64'd20);
`endif
        rx_req[0] = 1'b0;
        tick();

        // Inputs 1 and 3 contend for output 2 with its pointer at 0.
        set_req(1, 2); set_req(3, 2);
        tick();
        check("rr_first_ack", 64'(rx_ack), 64'(5'b00010));
        check("rr_first_txreq", 64'(tx_req), 64'(5'b00100));
        tx_done[2] = 1'b1;
        tick();
        tx_done[2] = 1'b0;
        check("release_txreq", 64'(tx_req), 64'(0));
        check("release_ack", 64'(rx_ack), 64'(5'b00010));
        rx_req[1] = 1'b0;
        tick();
        check("release_to_idle", 64'(rx_ack), 64'(0));
        tick();
        check("rr_second_ack", 64'(rx_ack), 64'(5'b01000));
        finish_pkt(2, 3);
        // Pointer now at 4: input 4 beats input 0.
        set_req(0, 2); set_req(4, 2);
        tick();
        check("ptr_at_4", 64'(rx_ack), 64'(5'b10000));
        finish_pkt(2, 4);
        finish_pkt(2, 0);

        // Grant to input 4 from output 0 wraps the pointer to 0.
        set_req(4, 0);
        tick();
        check("wrap_grant4", 64'(rx_ack), 64'(5'b10000));
        finish_pkt(0, 4);
        set_req(0, 0); set_req(4, 0);
        tick();
        check("wrap_grant0", 64'(rx_ack), 64'(5'b00001));
        finish_pkt(0, 0);
        finish_pkt(0, 4);

        // Crossbar path is combinational.
        set_req(2, 1);
        tick();
        tx_buf_addr[1*AW +: AW] = 3'd5;
        rx_buf_data[2*FW +: FW] = 8'hA5;
        #1;
        check("xbar_addr", 64'(rx_buf_addr[2*AW +: AW]), 64'd5);
        check("xbar_data", 64'(tx_buf_data[1*FW +: FW]), 64'hA5);
        finish_pkt(1, 2);

        // All five inputs to five distinct outputs at once.
        for (int i = 0; i < C; i++) set_req(i, (i + 1) % C);
        tick();
        check("all5_ack", 64'(rx_ack), 64'(5'b11111));
        check("all5_txreq", 64'(tx_req), 64'(5'b11111));
        tx_buf_addr = 15'($urandom);
        rx_buf_data = 40'({$urandom, $urandom});
        tick();
        tx_done = '1;
        tick();
        tx_done = '0;
        rx_req = '0;
        tick();
        tick();

        // Reset while output 2 is serving input 0, with other requests pending.
        set_req(0, 2);
        tick();
        set_req(1, 2); set_req(3, 2);
        tx_buf_addr = '1;
        rx_buf_data = '1;
        #3;
        reset = 1'b0;
        #1;
        check("rst_mid_ack", 64'(rx_ack), 64'(0));
        check("rst_mid_txreq", 64'(tx_req), 64'(0));
        check("rst_mid_addr", 64'(rx_buf_addr), 64'(0));
        check("rst_mid_data", 64'(tx_buf_data), 64'(0));
        model_reset();
        @(posedge clk); #1;
        check_outputs("in_reset");
        reset = 1'b1;
        tick();
        check("rst_lowest", 64'(rx_ack), 64'(5'b00001));

        // Randomised traffic against the model.
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < C; i++) begin
                if (!rx_req[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(i, ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4))
                                                              : int'($urandom_range(5, 7)));
                end else if (rx_ack[i] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0)) begin
                    rx_req[i] = 1'b0;
                end
            end
            for (int o = 0; o < C; o++) tx_done[o] = ($urandom_range(0, 3) == 0);
            tx_buf_addr = 15'($urandom);
            rx_buf_data = 40'({$urandom, $urandom});
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
